ghost_collision_ctrl: RTL and testbench
=======================================

GHOST_COLLISION_CTRL -- requirements
Module: ghost_collision_ctrl

Interface
REQ-001 Parameter HIT_DIST, default 12: collision threshold in pixels per axis.
REQ-002 Parameter INVULN_CYC, default 100000000: clock cycles of invulnerability after a hit.
REQ-003 Parameter SPEED_STEP, default 400: speed_offset increment per score point.
REQ-004 Parameter SCORE_MAX, default 9999: score saturation value.
REQ-005 Port clk, input, 1: single system clock.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port y_x, y_y, input, 10 each: Yoshi sprite top-left pixel position.
REQ-008 Port g_t_x, g_t_y, input, 10 each: top ghost top-left position.
REQ-009 Port g_b_x, g_b_y, input, 10 each: bottom ghost top-left position.
REQ-010 Port score_inc, input, 1: one-cycle pulse, one point scored.
REQ-011 Port start, input, 1: raw, asynchronous start-button level.
REQ-012 Port speed_offset, output, 26: feeds the ghost speed_offset inputs.
REQ-013 Port score, output, 14: current score.
REQ-014 Port lives, output, 2: remaining lives.
REQ-015 Port game_state, output, 2: encoded state, IDLE=0, PLAY=1, HIT=2, OVER=3.
REQ-016 Port hit_flash, output, 1: sprite blank/blink control for Yoshi during HIT.

Function
REQ-017 FSM states SHALL be IDLE, PLAY, HIT and OVER; all outputs SHALL be registered.
REQ-018 start SHALL pass through a 2-flop synchronizer followed by a rising-edge detector, giving start_pulse.
REQ-019 A collision with a ghost SHALL be declared when |y_x-g_x| < HIT_DIST and |y_y-g_y| < HIT_DIST.
- Differences are unsigned 10-bit magnitudes computed without wrap.
- coll = top collision OR bottom collision.
REQ-020 IDLE, on start_pulse: go to PLAY; set lives=3, score=0, speed_offset=0.
REQ-021 PLAY, on coll when lives > 1: decrement lives, clear the invuln counter, go to HIT.
REQ-022 PLAY, on coll when lives == 1: set lives=0 and go to OVER.
REQ-023 The state and lives changes SHALL be visible on the clock edge after the cycle in which coll is high.
REQ-024 HIT SHALL ignore coll, count INVULN_CYC cycles, then return to PLAY.
- The first cycle back in PLAY evaluates coll again.
REQ-025 OVER, on start_pulse: go to IDLE. All other inputs are ignored in OVER.
REQ-026 start_pulse in PLAY or HIT SHALL be ignored.
REQ-027 score_inc SHALL increment score only in PLAY or HIT, saturating at SCORE_MAX.
REQ-028 A simultaneous score_inc and coll SHALL apply both effects in the same cycle.
REQ-029 Collision with both ghosts in the same cycle SHALL cost exactly one life.
REQ-030 speed_offset SHALL equal score*SPEED_STEP, registered one cycle after score.
- Maximum value is 3999600, below 2^26.
REQ-031 hit_flash SHALL equal bit 22 of the invuln counter while in HIT, and 0 otherwise.
REQ-032 Score and speed_offset SHALL hold their values in OVER, and clear only on the IDLE-to-PLAY transition.

Reset
REQ-033 Reset SHALL asynchronously force: state=IDLE, lives=3, score=0, speed_offset=0, hit_flash=0, invuln counter=0, synchronizer flops=0.
REQ-034 Reset asserted mid-HIT or mid-OVER SHALL abort immediately; no start_pulse SHALL be generated on release while start is held high.
- The synchronizer and edge detector reset to 0.
- start is therefore still considered low at release, so a held start yields one pulse only after it has been seen low.

Structure
REQ-035 The state encodings and the default HIT_DIST, INVULN_CYC, SPEED_STEP and SCORE_MAX SHALL live in a shared game package.
- The ghost and Yoshi blocks share that package.
REQ-036 The synchronizer and edge detector SHALL be one sub-module, btn_edge, reusable for other buttons.
REQ-037 The multiply SHALL be implemented as a registered constant multiply; no DSP pipelining is required.

Verification
REQ-038 Reset, then start high for 3 cycles -> exactly one transition to PLAY, lives=3, score=0.
REQ-039 In PLAY, Yoshi at (100,100), top ghost at (111,100) -> next cycle lives=2, state=HIT.
- With the ghost at (112,100) instead -> no hit.
REQ-040 Both ghosts overlapping Yoshi for the whole HIT period (INVULN_CYC=20 in the bench) -> lives drops by 1 only.
- Then exactly 20 cycles in HIT, return to PLAY, and a further hit on the next cycle.
REQ-041 Lives=1 and coll together with score_inc -> state=OVER, lives=0, score +1.
- A later start_pulse -> IDLE.
- The next start_pulse -> PLAY with score=0.
REQ-042 Apply 10000 score_inc pulses -> score saturates at 9999 and speed_offset=3999600.
REQ-043 Assert reset during HIT -> immediately state=IDLE, lives=3, hit_flash=0.

Source files
------------

// File: rtl/ghost_collision_ctrl_pkg.sv
// Shared game definitions: state encoding, default tuning constants, collision helper.
// Pure declarations; no latency, no flow control.
package ghost_collision_ctrl_pkg;

    localparam int DEF_HIT_DIST   = 12;
    localparam int DEF_INVULN_CYC = 100000000;
    localparam int DEF_SPEED_STEP = 400;
    localparam int DEF_SCORE_MAX  = 9999;

    // Wide enough for the default invulnerability period and the blink bit.
    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } game_state_t;

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/ghost_collision_ctrl_btn_edge.sv
// Button synchronizer plus rising-edge detector; pulse follows the pin by 2-3 cycles.
// A level already high when reset releases is never reported until it has been seen low.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic       sync0;
    logic       sync1;
    logic       prev;
    logic       armed;
    logic [1:0] fill;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            prev  <= 1'b0;
            armed <= 1'b0;
            fill  <= 2'b00;
        end else begin
            sync0 <= btn;
            sync1 <= sync0;
            prev  <= sync1;
            fill  <= {fill[0], 1'b1};
            // Arm only once sync1 holds a genuine low sample, not the reset value.
            if (fill[1] && !sync1)
                armed <= 1'b1;
        end
    end

    assign pulse = armed & sync1 & ~prev;

endmodule

// File: rtl/ghost_collision_ctrl.sv
// Game control FSM: collisions, lives, score and ghost speed for the Yoshi game.
// State/lives react one edge after coll; speed_offset trails score by one cycle; no backpressure.
module ghost_collision_ctrl #(
    parameter int HIT_DIST   = ghost_collision_ctrl_pkg::DEF_HIT_DIST,
    parameter int INVULN_CYC = ghost_collision_ctrl_pkg::DEF_INVULN_CYC,
    parameter int SPEED_STEP = ghost_collision_ctrl_pkg::DEF_SPEED_STEP,
    parameter int SCORE_MAX  = ghost_collision_ctrl_pkg::DEF_SCORE_MAX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  y_x,
    input  logic [9:0]  y_y,
    input  logic [9:0]  g_t_x,
    input  logic [9:0]  g_t_y,
    input  logic [9:0]  g_b_x,
    input  logic [9:0]  g_b_y,
    input  logic        score_inc,
    input  logic        start,
    output logic [25:0] speed_offset,
    output logic [13:0] score,
    output logic [1:0]  lives,
    output logic [1:0]  game_state,
    output logic        hit_flash
);

    import ghost_collision_ctrl_pkg::*;

    localparam logic [9:0]       HIT_D    = 10'(HIT_DIST);
    localparam logic [CNT_W-1:0] INV_LAST = CNT_W'(INVULN_CYC - 1);
    localparam logic [13:0]      SC_MAX   = 14'(SCORE_MAX);
    localparam logic [25:0]      STEP     = 26'(SPEED_STEP);

    game_state_t      state;
    game_state_t      state_n;
    logic [1:0]       lives_n;
    logic [13:0]      score_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             flash_n;
    logic             clear_speed;
    logic             start_pulse;
    logic             coll_top;
    logic             coll_bot;
    logic             coll;

    btn_edge u_start (
        .clk   (clk),
        .reset (reset),
        .btn   (start),
        .pulse (start_pulse)
    );

    assign coll_top = (abs_diff(y_x, g_t_x) < HIT_D) && (abs_diff(y_y, g_t_y) < HIT_D);
    assign coll_bot = (abs_diff(y_x, g_b_x) < HIT_D) && (abs_diff(y_y, g_b_y) < HIT_D);
    assign coll     = coll_top | coll_bot;

    always_comb begin
        state_n     = state;
        lives_n     = lives;
        score_n     = score;
        cnt_n       = cnt;
        clear_speed = 1'b0;

        if ((state == ST_PLAY || state == ST_HIT) && score_inc && score < SC_MAX)
            score_n = score + 14'd1;

        case (state)
            ST_IDLE: begin
                if (start_pulse) begin
                    state_n     = ST_PLAY;
                    lives_n     = 2'd3;
                    score_n     = 14'd0;
                    clear_speed = 1'b1;
                end
            end
            ST_PLAY: begin
                if (coll) begin
                    if (lives > 2'd1) begin
                        lives_n = lives - 2'd1;
                        cnt_n   = '0;
                        state_n = ST_HIT;
                    end else begin
                        lives_n = 2'd0;
                        state_n = ST_OVER;
                    end
                end
            end
            ST_HIT: begin
                if (cnt == INV_LAST)
                    state_n = ST_PLAY;
                else
                    cnt_n = cnt + 1'b1;
            end
            ST_OVER: begin
                if (start_pulse)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        flash_n = (state_n == ST_HIT) && cnt_n[22];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            lives        <= 2'd3;
            score        <= 14'd0;
            speed_offset <= 26'd0;
            cnt          <= '0;
            hit_flash    <= 1'b0;
        end else begin
            state        <= state_n;
            lives        <= lives_n;
            score        <= score_n;
            cnt          <= cnt_n;
            hit_flash    <= flash_n;
            speed_offset <= clear_speed ? 26'd0 : ({12'd0, score} * STEP);
        end
    end

    assign game_state = state;

endmodule

// File: tb/tb_ghost_collision_ctrl.sv
// Self-checking bench for ghost_collision_ctrl: collision vector table plus multi-cycle game sequences.
module tb_ghost_collision_ctrl;

    localparam int INV = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  y_x, y_y, g_t_x, g_t_y, g_b_x, g_b_y;
    logic        score_inc;
    logic        start;
    logic [25:0] speed_offset;
    logic [13:0] score;
    logic [1:0]  lives;
    logic [1:0]  game_state;
    logic        hit_flash;

    always #5 clk = ~clk;

    ghost_collision_ctrl #(
        .HIT_DIST   (12),
        .INVULN_CYC (INV),
        .SPEED_STEP (400),
        .SCORE_MAX  (9999)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .y_x          (y_x),
        .y_y          (y_y),
        .g_t_x        (g_t_x),
        .g_t_y        (g_t_y),
        .g_b_x        (g_b_x),
        .g_b_y        (g_b_y),
        .score_inc    (score_inc),
        .start        (start),
        .speed_offset (speed_offset),
        .score        (score),
        .lives        (lives),
        .game_state   (game_state),
        .hit_flash    (hit_flash)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  st;
        logic [1:0]  lv;
        logic [13:0] sc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    typedef struct {
        int yx, yy, tx, ty, bx, by;
        bit hit;
    } vec_t;

    vec_t vecs[11];

    int         play_entries = 0;
    logic [1:0] prev_gs = 2'd0;

    always @(negedge clk) begin
        if (game_state == 2'd1 && prev_gs != 2'd1)
            play_entries++;
        prev_gs = game_state;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string nm, input logic [1:0] st, input logic [1:0] lv,
                           input logic [13:0] sc);
        exp_t e;
        e.st = st;
        e.lv = lv;
        e.sc = sc;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic sb_pop();
        exp_t  e;
        string nm;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk({nm, ".state"}, 32'(game_state), 32'(e.st));
        chk({nm, ".lives"}, 32'(lives), 32'(e.lv));
        chk({nm, ".score"}, 32'(score), 32'(e.sc));
    endtask

    task automatic wait_state(input string nm, input logic [1:0] st, input int budget);
        int n = 0;
        while (game_state !== st && n < budget) begin
            step();
            n++;
        end
        chk({nm, ".reached"}, 32'(game_state), 32'(st));
    endtask

    task automatic park();
        y_x = 10'd100; y_y = 10'd100;
        g_t_x = 10'd500; g_t_y = 10'd500;
        g_b_x = 10'd600; g_b_y = 10'd600;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (4) step();
    endtask

    task automatic go_play(input string nm);
        start = 1'b0;
        score_inc = 1'b0;
        park();
        do_reset();
        start = 1'b1;
        wait_state({nm, ".play"}, 2'd1, 10);
        start = 1'b0;
        repeat (3) step();
    endtask

    task automatic press(input string nm, input logic [1:0] st);
        start = 1'b1;
        wait_state(nm, st, 10);
        start = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        int hit_n;

        vecs[0]  = '{100, 100, 111, 100, 500, 500, 1'b1};
        vecs[1]  = '{100, 100, 112, 100, 500, 500, 1'b0};
        vecs[2]  = '{100, 100,  89, 100, 500, 500, 1'b1};
        vecs[3]  = '{100, 100,  88, 100, 500, 500, 1'b0};
        vecs[4]  = '{100, 100, 100, 111, 500, 500, 1'b1};
        vecs[5]  = '{100, 100, 100, 112, 500, 500, 1'b0};
        vecs[6]  = '{100, 100, 500, 500, 111, 111, 1'b1};
        vecs[7]  = '{100, 100, 500, 500, 112, 111, 1'b0};
        vecs[8]  = '{  0,   0,  11,   5, 500, 500, 1'b1};
        vecs[9]  = '{  5,   0, 1023,  0, 500, 500, 1'b0};
        vecs[10] = '{1023, 1023, 0,   0, 1012, 1013, 1'b1};

        reset = 1'b1;
        start = 1'b0;
        score_inc = 1'b0;
        park();
        step();
        chk("rst.state", 32'(game_state), 32'd0);
        chk("rst.lives", 32'(lives), 32'd3);
        chk("rst.score", 32'(score), 32'd0);
        chk("rst.speed", 32'(speed_offset), 32'd0);
        chk("rst.flash", 32'(hit_flash), 32'd0);
        reset = 1'b0;
        repeat (4) step();

        // Start held for three cycles must enter PLAY exactly once.
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        repeat (8) step();
        chk("start3.entries", 32'(play_entries), 32'd1);
        chk("start3.state", 32'(game_state), 32'd1);
        chk("start3.lives", 32'(lives), 32'd3);
        chk("start3.score", 32'(score), 32'd0);

        for (int i = 0; i < 11; i++) begin
            go_play("vec");
            y_x = 10'(vecs[i].yx);   y_y = 10'(vecs[i].yy);
            g_t_x = 10'(vecs[i].tx); g_t_y = 10'(vecs[i].ty);
            g_b_x = 10'(vecs[i].bx); g_b_y = 10'(vecs[i].by);
            if (vecs[i].hit)
                sb_push($sformatf("vec%0d", i), 2'd2, 2'd2, 14'd0);
            else
                sb_push($sformatf("vec%0d", i), 2'd1, 2'd3, 14'd0);
            step();
            sb_pop();
        end

        // Both ghosts overlapping for the whole invulnerability period.
        go_play("dbl");
        g_t_x = 10'd100; g_t_y = 10'd100;
        g_b_x = 10'd105; g_b_y = 10'd95;
        sb_push("dbl.hit", 2'd2, 2'd2, 14'd0);
        step();
        sb_pop();
        chk("dbl.flash", 32'(hit_flash), 32'd0);
        hit_n = 1;
        while (game_state == 2'd2 && hit_n < 100) begin
            step();
            if (game_state == 2'd2)
                hit_n++;
        end
        chk("dbl.hit_cycles", 32'(hit_n), 32'(INV));
        chk("dbl.ret_state", 32'(game_state), 32'd1);
        chk("dbl.ret_lives", 32'(lives), 32'd2);
        sb_push("dbl.rehit", 2'd2, 2'd1, 14'd0);
        step();
        sb_pop();

        // Last life lost together with a score point.
        wait_state("last.back", 2'd1, 40);
        score_inc = 1'b1;
        sb_push("last.over", 2'd3, 2'd0, 14'd1);
        step();
        score_inc = 1'b0;
        sb_pop();
        step();
        chk("last.speed", 32'(speed_offset), 32'd400);
        score_inc = 1'b1;
        step();
        score_inc = 1'b0;
        step();
        sb_push("over.ignore", 2'd3, 2'd0, 14'd1);
        sb_pop();
        park();
        press("over.to_idle", 2'd0);
        chk("idle.score_hold", 32'(score), 32'd1);
        chk("idle.speed_hold", 32'(speed_offset), 32'd400);
        press("idle.to_play", 2'd1);
        sb_push("replay", 2'd1, 2'd3, 14'd0);
        sb_pop();
        chk("replay.speed", 32'(speed_offset), 32'd0);

        // Start ignored in PLAY, then score saturation.
        go_play("sat");
        start = 1'b1;
        repeat (6) step();
        start = 1'b0;
        repeat (4) step();
        chk("sat.start_ignored", 32'(game_state), 32'd1);
        for (int i = 0; i < 10000; i++) begin
            score_inc = 1'b1;
            step();
            score_inc = 1'b0;
            step();
            if (i == 9) begin
                chk("sat.score10", 32'(score), 32'd10);
                chk("sat.speed10", 32'(speed_offset), 32'd4000);
            end
        end
        chk("sat.score", 32'(score), 32'd9999);
        chk("sat.speed", 32'(speed_offset), 32'd3999600);

        // Reset in the middle of HIT, with start held through release.
        go_play("rhit");
        g_t_x = 10'd104; g_t_y = 10'd100;
        step();
        chk("rhit.in_hit", 32'(game_state), 32'd2);
        #2;
        reset = 1'b1;
        start = 1'b1;
        #1;
        chk("rhit.state", 32'(game_state), 32'd0);
        chk("rhit.lives", 32'(lives), 32'd3);
        chk("rhit.flash", 32'(hit_flash), 32'd0);
        park();
        step();
        step();
        reset = 1'b0;
        repeat (10) step();
        chk("rhit.no_pulse", 32'(game_state), 32'd0);
        start = 1'b0;
        repeat (4) step();
        press("rhit.replay", 2'd1);

        chk("sb.drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
